ram_port: RTL and testbench

RAM_PORT -- requirements
Module: ram_port

---
 rtl/ram_port.sv | 149 ++++++++++++++
 tb/tb_ram_port.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port.sv
// ram_port: request/response front end for a single-port synchronous-read RAM.
// Writes take two cycles (WR). Reads take three cycles (RD_A, RD_B, RSP), and
// the response is held until the consumer takes it.
// Optional full-array fill is enabled by defining RAM_CLEAR_EN. When it is
// undefined, clr_start and clr_value are ignored and clr_busy is tied low.
module ram_port #(
    parameter int WORDS  = 256,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_data,
    input  logic              clr_start,
    input  logic [WIDTH-1:0]  clr_value,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_write,
    output logic [WIDTH-1:0]  ram_d_in,
    input  logic [WIDTH-1:0]  ram_d_out
);

`ifdef RAM_CLEAR_EN
    typedef enum logic [2:0] {IDLE, WR, RD_A, RD_B, RSP, CLEAR} state_t;
`else
    typedef enum logic [2:0] {IDLE, WR, RD_A, RD_B, RSP} state_t;
`endif

    state_t state, nxt;
    logic   accept;

`ifdef RAM_CLEAR_EN
    logic [ADDR_W-1:0] cnt;
    logic              clr_last;

    assign clr_last  = (cnt == ADDR_W'(WORDS - 1));
    // A pending fill request blocks new requests, even in IDLE.
    assign req_ready = (state == IDLE) && !clr_start;
`else
    logic unused_clr;

    assign unused_clr = ^{clr_start, clr_value};
    assign req_ready  = (state == IDLE);
    assign clr_busy   = 1'b0;
`endif

    assign accept = req_valid && req_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // Next-state logic. In IDLE, a fill request takes priority over a new request.
    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
`ifdef RAM_CLEAR_EN
                if (clr_start) nxt = CLEAR;
                else
`endif
                if (accept) nxt = req_write ? WR : RD_A;
            end
            WR:    nxt = IDLE;
            RD_A:  nxt = RD_B;
            RD_B:  nxt = RSP;
            RSP:   if (rsp_ready) nxt = IDLE;
`ifdef RAM_CLEAR_EN
            CLEAR: if (clr_last) nxt = IDLE;
`endif
            default: nxt = IDLE;
        endcase
    end

    // Registered RAM strobes and response. ram_addr keeps its last value
    // unless a new address is launched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr  <= '0;
            ram_write <= 1'b0;
            ram_d_in  <= '0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
        end else begin
            ram_write <= 1'b0;
            case (state)
                IDLE: begin
`ifdef RAM_CLEAR_EN
                    if (clr_start) begin
                        ram_write <= 1'b1;
                        ram_addr  <= '0;
                        ram_d_in  <= clr_value;
                    end else
`endif
                    if (accept) begin
                        ram_addr <= req_addr;
                        if (req_write) begin
                            ram_write <= 1'b1;
                            ram_d_in  <= req_data;
                        end
                    end
                end
                // RAM data for the RD_A address is valid during RD_B.
                RD_B: begin
                    rsp_data  <= ram_d_out;
                    rsp_valid <= 1'b1;
                end
                RSP: if (rsp_ready) rsp_valid <= 1'b0;
`ifdef RAM_CLEAR_EN
                CLEAR: if (!clr_last) begin
                    ram_write <= 1'b1;
                    ram_addr  <= cnt + 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef RAM_CLEAR_EN
    // Fill counter and busy flag. The counter returns to 0 only when the fill completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            clr_busy <= 1'b0;
        end else if (state == IDLE && clr_start) begin
            cnt      <= '0;
            clr_busy <= 1'b1;
        end else if (state == CLEAR) begin
            if (clr_last) begin
                cnt      <= '0;
                clr_busy <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ram_port.sv
// tb_ram_port: randomized scoreboard bench for ram_port. Includes a
// synchronous-read RAM model and a flat-array reference memory. When
// RAM_CLEAR_EN is defined, the fill scenario runs. Otherwise, the bench checks
// that the fill inputs are ignored.
module tb_ram_port;
    localparam int WORDS = 256;
    localparam int WIDTH = 8;
    localparam int AW    = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, req_ready, req_write;
    logic [AW-1:0]    req_addr;
    logic [WIDTH-1:0] req_data;
    logic             rsp_valid, rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             clr_start, clr_busy;
    logic [WIDTH-1:0] clr_value;
    logic [AW-1:0]    ram_addr;
    logic             ram_write;
    logic [WIDTH-1:0] ram_d_in, ram_d_out;

    ram_port #(.WORDS(WORDS), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .clr_start(clr_start), .clr_value(clr_value), .clr_busy(clr_busy),
        .ram_addr(ram_addr), .ram_write(ram_write), .ram_d_in(ram_d_in),
        .ram_d_out(ram_d_out)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM that the DUT drives.
    logic [WIDTH-1:0] ram_mem [WORDS];
    always @(posedge clk) begin
        if (ram_write) ram_mem[ram_addr] <= ram_d_in;
        ram_d_out <= ram_mem[ram_addr];
    end

    typedef struct { logic [WIDTH-1:0] data; int due; } exp_t;
    exp_t             exp_q[$];
    exp_t             mon_e;
    logic [WIDTH-1:0] model [WORDS];
    int               errors = 0, checks = 0, cyc = 0;
    int               rr_mode = 1;   // 0: hold low, 1: hold high, 2: random
    bit               in_rsp = 1'b0;
    logic [WIDTH-1:0] held;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        rsp_ready = (rr_mode == 2) ? 1'($urandom_range(0, 1)) : (rr_mode == 1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: checks latency on the first cycle of a response, checks that
    // the response stays stable while held, and checks the data at handshake.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (!in_rsp) begin
                in_rsp = 1'b1;
                held   = rsp_data;
                if (exp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 0);
                else                   chk("rsp_latency", cyc, exp_q[0].due);
            end else begin
                chk("rsp_stable", 32'(rsp_data), 32'(held));
            end
            if (rsp_ready) begin
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
                end
                in_rsp = 1'b0;
            end
        end
    end

    // Issue one request and wait, with a bound, for its acceptance edge.
    task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        int n = 0;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_data = d;
        @(negedge clk);
        while (!req_ready && n < 2000) begin @(negedge clk); n++; end
        chk("req_accept", 32'(req_ready), 1);
        if (req_ready) begin
            if (wr) model[a] = d;
            else    exp_q.push_back('{model[a], cyc + 3});
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 1000) begin @(posedge clk); #1; n++; end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_ram_addr"},  32'(ram_addr),  0);
        chk({tag, "_ram_write"}, 32'(ram_write), 0);
        chk({tag, "_ram_d_in"},  32'(ram_d_in),  0);
        chk({tag, "_rsp_data"},  32'(rsp_data),  0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_clr_busy"},  32'(clr_busy),  0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
        clr_start = 1'b0; clr_value = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outs("reset");
        chk("reset_req_ready", 32'(req_ready), 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Fill the RAM with a known pattern through the DUT.
        for (int i = 0; i < WORDS; i++) issue(1'b1, AW'(i), WIDTH'(i ^ 'h5A));

        // Basic write, then read, sequence.
        issue(1'b1, 8'h00, 8'h02);
        issue(1'b1, 8'h01, 8'h03);
        issue(1'b1, 8'h02, 8'h05);
        chk("wr_strobe", 32'(ram_write), 1);
        chk("wr_addr",   32'(ram_addr),  32'h02);
        chk("wr_data",   32'(ram_d_in),  32'h05);
        @(posedge clk); #1;
        chk("wr_strobe_off", 32'(ram_write), 0);
        chk("wr_idle_ready", 32'(req_ready), 1);
        issue(1'b0, 8'h00, 8'h00);
        issue(1'b0, 8'h01, 8'h00);
        issue(1'b0, 8'h02, 8'h00);
        wait_drain();

        // Back-to-back write, then read of the same address.
        issue(1'b1, 8'h10, 8'h7E);
        issue(1'b0, 8'h10, 8'h00);
        wait_drain();

        // A stalled response holds its data and blocks new requests.
        rr_mode = 0;
        issue(1'b0, 8'hFF, 8'h00);
        @(posedge clk); @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid",   32'(rsp_valid), 1);
            chk("hold_noready", 32'(req_ready), 0);
        end
        @(posedge clk); #1;
        rr_mode = 1; rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("rsp_drop",       32'(rsp_valid), 0);
        chk("idle_after_rsp", 32'(req_ready), 1);
        wait_drain();

        // Reset in RD_B drops the pending response.
        issue(1'b0, 8'h20, 8'h00);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        in_rsp = 1'b0;
        #1;
        chk_zero_outs("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        issue(1'b0, 8'h20, 8'h00);
        wait_drain();

`ifdef RAM_CLEAR_EN
        // A fill request takes priority over a simultaneous write.
        clr_value = 8'hA5; clr_start = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h80; req_data = 8'h11;
        @(negedge clk);
        chk("clr_blocks_req", 32'(req_ready), 0);
        @(posedge clk); #1;
        clr_start = 1'b0; req_valid = 1'b0; clr_value = 8'h3C;
        chk("clr_busy_start", 32'(clr_busy), 1);
        n = 0;
        @(negedge clk);
        while (clr_busy && n < WORDS + 20) begin
            n++;
            if (n == 50)  chk("clr_noready", 32'(req_ready), 0);
            if (n == 100) clr_start = 1'b1;
            if (n == 104) clr_start = 1'b0;
            @(negedge clk);
        end
        chk("clr_busy_cycles", n, WORDS);
        for (int i = 0; i < WORDS; i++) model[i] = 8'hA5;
        @(posedge clk); #1;
        issue(1'b0, 8'h00, 8'h00);
        issue(1'b0, 8'h80, 8'h00);
        issue(1'b0, 8'hFF, 8'h00);
        wait_drain();
`else
        // With the fill disabled, clr_start is ignored.
        clr_value = 8'hA5; clr_start = 1'b1;
        issue(1'b0, 8'h01, 8'h00);
        @(negedge clk);
        chk("noclr_busy", 32'(clr_busy), 0);
        wait_drain();
        chk("noclr_busy_end", 32'(clr_busy), 0);
        clr_start = 1'b0;
        n = 0;
`endif

        // Randomized traffic with a random consumer. Half of the addresses
        // fall in a small window so that read-after-write hits are common.
        rr_mode = 2;
        for (int i = 0; i < 300; i++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            issue(1'($urandom_range(0, 1)), a, WIDTH'($urandom));
        end
        wait_drain();
        rr_mode = 1;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
